// File: rtl/core_lsu_op_arb_pkg.sv
// Shared LSU definitions for the slow-path operation arbiter: op-type codes,
// arbiter state encoding and the way-selection LFSR constants.
`ifndef _DWAY_CNT
`define _DWAY_CNT 4
`endif

package core_lsu_op_arb_pkg;

  // Slow-path operation types as seen by the write-port state machine
  localparam logic [1:0] O_READ_REFILL  = 2'd0;
  localparam logic [1:0] O_WRITE_REFILL = 2'd1;
  localparam logic [1:0] O_READ_UNCACHE = 2'd2;
  localparam logic [1:0] O_CACHE_INV    = 2'd3;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StDone  = 2'd3
  } lsu_arb_state_e;

  // 16-bit Galois LFSR used for pseudo-random replacement way choice
  localparam logic [15:0] LFSR_RESET = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;

  // One Galois step: shift right, fold taps back in when a one falls out
  function automatic logic [15:0] lfsr16_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction

endpackage

// File: rtl/core_lsu_lfsr16.sv
// Free-running 16-bit Galois LFSR; supplies replacement-way bits to the
// slow-path arbiter. Synchronous active-low reset.
module core_lsu_lfsr16
  import core_lsu_op_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] value
);

  logic [15:0] lfsr_q;

  // Advance every cycle regardless of arbiter activity
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_RESET;
    end else begin
      lfsr_q <= lfsr16_next(lfsr_q);
    end
  end

  assign value = lfsr_q;

endmodule

// File: rtl/core_lsu_op_arb.sv
// Slow-path operation arbiter in front of the LSU write-port state machine.
// Grants one pipe request at a time, merges same-line read refills, holds the
// registered op until the write port accepts and finishes it, then pulses
// completion back to the still-interested owner pipes.
// Optional: define LSU_ARB_RR_EN for round-robin priority (default: fixed,
// pipe 0 highest, and no pointer register).
`ifndef _DWAY_CNT
`define _DWAY_CNT 4
`endif

module core_lsu_op_arb
  import core_lsu_op_arb_pkg::*;
#(
  parameter int unsigned PIPE_MANAGE_NUM = 2,
  parameter int unsigned WAY_CNT         = `_DWAY_CNT,
  parameter int unsigned LINE_BYTES      = 16,
  localparam int unsigned WAY_W          = $clog2(WAY_CNT),
  localparam int unsigned PIPE_W         = (PIPE_MANAGE_NUM > 1) ? $clog2(PIPE_MANAGE_NUM) : 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [PIPE_MANAGE_NUM-1:0]            req_valid_i,
  input  logic [PIPE_MANAGE_NUM-1:0][1:0]       req_type_i,
  input  logic [PIPE_MANAGE_NUM-1:0][31:0]      req_addr_i,
  input  logic [PIPE_MANAGE_NUM-1:0][WAY_W-1:0] req_way_i,
  output logic [PIPE_MANAGE_NUM-1:0]            req_done_o,
  output logic                                  op_valid_o,
  output logic [1:0]                            op_type_o,
  output logic [31:0]                           op_addr_o,
  output logic [WAY_W-1:0]                      op_sel_o,
  input  logic                                  op_ready_i,
  input  logic                                  op_done_i,
  output logic                                  busy_o
);

  localparam logic [31:0] LINE_MASK = ~(32'(LINE_BYTES) - 32'd1);

  lsu_arb_state_e state_q, state_d;

  logic [15:0]                lfsr_val;
  logic                       found;
  logic [PIPE_W-1:0]          win;
  logic [PIPE_W-1:0]          idx;
  logic [1:0]                 win_type;
  logic [31:0]                win_line;
  logic [31:0]                grant_addr;
  logic [WAY_W-1:0]           grant_sel;
  logic [PIPE_MANAGE_NUM-1:0] grant_owner;

  logic [1:0]                 type_q;
  logic [31:0]                addr_q;
  logic [WAY_W-1:0]           sel_q;
  logic [PIPE_MANAGE_NUM-1:0] owner_q;

  core_lsu_lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .value (lfsr_val)
  );

  // Only the low way-index bits of the LFSR feed the replacement choice
  logic unused_lfsr;
  assign unused_lfsr = ^lfsr_val[15:WAY_W];

`ifdef LSU_ARB_RR_EN
  logic [PIPE_W-1:0] ptr_q;

  // Rotate priority: the pipe after the last winner searches first next time
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (state_q == StIdle && found) begin
      ptr_q <= PIPE_W'((32'(win) + 32'd1) % PIPE_MANAGE_NUM);
    end
  end
`endif

  // Winner search: start at the pointer (round-robin) or at pipe 0 (fixed)
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < PIPE_MANAGE_NUM; k++) begin
`ifdef LSU_ARB_RR_EN
      idx = PIPE_W'((32'(ptr_q) + 32'(k)) % PIPE_MANAGE_NUM);
`else
      idx = PIPE_W'(k);
`endif
      if (!found && req_valid_i[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Grant payload: aligned address, way choice and merged owner set
  always_comb begin
    win_type   = req_type_i[win];
    win_line   = req_addr_i[win] & LINE_MASK;
    grant_addr = (win_type == O_READ_UNCACHE) ? req_addr_i[win] : win_line;
    case (win_type)
      O_READ_REFILL, O_WRITE_REFILL: grant_sel = lfsr_val[WAY_W-1:0];
      O_CACHE_INV:                   grant_sel = req_way_i[win];
      default:                       grant_sel = '0;
    endcase
    grant_owner      = '0;
    grant_owner[win] = 1'b1;
    // Other pipes refilling the same line ride on the winner's bus transaction
    for (int j = 0; j < PIPE_MANAGE_NUM; j++) begin
      if (req_valid_i[j] && (req_type_i[j] == O_READ_REFILL) &&
          (win_type == O_READ_REFILL) && ((req_addr_i[j] & LINE_MASK) == win_line)) begin
        grant_owner[j] = 1'b1;
      end
    end
  end

  // Next-state: grant, wait for acceptance, wait for completion, report
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (found)      state_d = StIssue;
      // op_done_i here is deliberately ignored even with op_ready_i high
      StIssue: if (op_ready_i) state_d = StWait;
      StWait:  if (op_done_i)  state_d = StDone;
      StDone:                  state_d = StIdle;
      default:                 state_d = StIdle;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture the grant; drop owners that withdraw while the op is in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      type_q  <= '0;
      addr_q  <= '0;
      sel_q   <= '0;
      owner_q <= '0;
    end else if (state_q == StIdle && found) begin
      type_q  <= win_type;
      addr_q  <= grant_addr;
      sel_q   <= grant_sel;
      owner_q <= grant_owner;
    end else if (state_q == StIssue || state_q == StWait) begin
      owner_q <= owner_q & req_valid_i;
    end
  end

  assign op_valid_o = (state_q == StIssue);
  assign op_type_o  = type_q;
  assign op_addr_o  = addr_q;
  assign op_sel_o   = sel_q;
  assign busy_o     = (state_q != StIdle);
  // A killed pipe gets no pulse even though the bus op ran to completion
  assign req_done_o = (state_q == StDone) ? (owner_q & req_valid_i) : '0;

  // The write port must see a stable op until it accepts it
  a_op_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (op_valid_o && !op_ready_i) |=> (op_valid_o && $stable(op_addr_o) && $stable(op_sel_o)));

  a_done_only_busy: assert property (@(posedge clk) disable iff (!rst_n)
    !busy_o |-> (req_done_o == '0));

endmodule

// File: doc/core_lsu_op_arb.md
# core_lsu_op_arb

- Sits directly upstream of the LSU write-port state machine: its registered output is that machine's operation input.
- Collects slow-path requests (read refill, write refill, uncached read, cache invalidate) from each managed LSU pipe and arbitrates among them.
- Picks the replacement way for refills, holds the granted operation until the write port accepts and completes it, then pulses completion back to the requesting pipe(s).
- Merges identical-line refill requests so one bus transaction serves several pipes.

## Interface
Parameters:
- PIPE_MANAGE_NUM, 2, number of requesting LSU pipes (1..4)
- WAY_CNT, `_DWAY_CNT, cache ways; power of two, >=2
- LINE_BYTES, 16, cache line size; power of two

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- req_valid_i  in  PIPE_MANAGE_NUM  per-pipe request; held until req_done_o or pipe kill
- req_type_i  in  PIPE_MANAGE_NUM x 2  0 read refill, 1 write refill, 2 uncached read, 3 cache inv
- req_addr_i  in  PIPE_MANAGE_NUM x 32  physical byte address
- req_way_i  in  PIPE_MANAGE_NUM x log2(WAY_CNT)  target way, used for type 3 only
- req_done_o  out  PIPE_MANAGE_NUM  one-cycle completion pulse per pipe
- op_valid_o  out  1  operation valid toward write port
- op_type_o  out  2  granted type
- op_addr_o  out  32  granted address; line-aligned (low log2(LINE_BYTES) bits zero) for types 0, 1, 3; unmodified for type 2
- op_sel_o  out  log2(WAY_CNT)  refill/writeback way
- op_ready_i  in  1  write port accepts op (handshake when op_valid_o && op_ready_i)
- op_done_i  in  1  write port finished accepted op (single-cycle pulse)
- busy_o  out  1  high in any state except IDLE

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- **IDLE:** if any req_valid_i is high, choose a winner (see Configuration) and register type, address, way and owner mask. Go to ISSUE.
- **Way select:**
  - Types 0 and 1: op_sel = lfsr[log2(WAY_CNT)-1:0], sampled in the grant cycle.
  - Type 3: op_sel = winner's req_way_i.
  - Type 2: op_sel = 0.
- **ISSUE:** op_valid_o = 1; registered outputs stay stable. On op_ready_i, go to WAIT.
- **WAIT:** wait for op_done_i, then go to DONE.
- **DONE:** req_done_o = owner mask & req_valid_i for one cycle. Return to IDLE.
- **Owner mask / merge:** the winner, plus every other pipe whose request is valid in the grant cycle, has type 0, and has the same line address as a type-0 winner.
- **Pipe kill:** if a pipe drops req_valid_i while it is in the owner mask, the operation still runs to completion (bus ops are not abortable). That pipe gets no done pulse.
- **LFSR:**
  - 16-bit Galois, taps mask 16'hB400, reset value 16'hACE1.
  - Shifts every cycle regardless of state.
- op_done_i outside WAIT is ignored.

## Timing
- **Reset:** all outputs 0, state IDLE, LFSR 16'hACE1, round-robin pointer 0.
- **Request to op_valid_o:** 1 cycle (request sampled in IDLE at edge N, op_valid_o high from N+1).
- op_valid_o stays high until the handshake cycle inclusive. It drops the cycle after.
- **op_done_i to req_done_o:** 1 cycle.
- **Back-to-back:** from the DONE cycle, the next grant is sampled at the following edge. Minimum 4 cycles per op when op_ready_i and op_done_i arrive immediately.
- op_ready_i and op_done_i both high in the ISSUE cycle: op_done_i is ignored; the block waits for a later op_done_i.
- **Reset mid-operation:** state returns to IDLE. No done pulses are produced.

## Configuration
- **LSU_ARB_RR_EN defined:** round-robin priority.
  - Search starts at the pointer; pointer = winner+1 (mod PIPE_MANAGE_NUM) after each grant.
- **LSU_ARB_RR_EN undefined:** fixed priority, pipe 0 highest. The pointer register is not built.

## Structure
- Shared LSU package holds:
  - the op-type localparams (O_READ_REFILL=0, O_WRITE_REFILL=1, O_READ_UNCACHE=2, O_CACHE_INV=3)
  - the state enum
  - the LFSR reset and tap constants
- One sub-module: core_lsu_lfsr16 (clk, rst_n, value out).

## Test plan
- **Single request:** pipe 0 type 0 addr 32'h1000_0034, op_ready_i immediate, op_done_i 3 cycles later.
  - Required: op_addr_o = 32'h1000_0030.
  - Required: op_sel_o equals LFSR bits at grant.
  - Required: req_done_o = 2'b01 one cycle after op_done_i.
- **Merge:** pipes 0 and 1 both type 0, addrs 32'h2000_0004 and 32'h2000_000C.
  - Required: exactly one op handshake, then req_done_o = 2'b11.
- **Round-robin (LSU_ARB_RR_EN):** pipes 0 and 1 continuously request different lines.
  - Required: grants alternate 0, 1, 0. Without the macro, pipe 0 always wins.
- **Invalidate:** pipe 1 type 3, addr 32'h0000_0F0F, req_way_i = 1.
  - Required: op_addr_o = 32'h0000_0F00, op_sel_o = 1.
- **Kill:** pipe 0 drops req_valid_i during WAIT.
  - Required: op completes, req_done_o stays 0, busy_o clears after DONE.
- **Reset in WAIT:** assert rst_n = 0 for 1 cycle.
  - Required: all outputs 0 the next cycle, and no spurious done pulse when op_done_i arrives afterwards.
